// File: rtl/pipeline_decode_stage_if.sv
// Handshake and decoded-payload bundle for pipeline_decode_stage.
// The slave modport is the decode stage; the master modport is whoever feeds and drains it.
interface pipeline_decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int RA_W   = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       ir_in;
  logic [PC_W-1:0]   pc_in;
  logic              flush;
  logic              resume;
  logic              out_valid;
  logic              out_ready;
  logic              halted;
  logic [2:0]        opcode;
  logic [PC_W-1:0]   pc;
  logic              asel;
  logic              bsel;
  logic              loads;
  logic [1:0]        aluop;
  logic [1:0]        shift;
  logic              write;
  logic [RA_W-1:0]   writenum;
  logic [RA_W-1:0]   num_rm;
  logic [RA_W-1:0]   num_rn;
  logic [RA_W-1:0]   num_rd;
  logic [2:0]        used_rmrnrd;
  logic [5:0]        inst_type;
  logic [DATA_W-1:0] sximm;
  logic              illegal;

  modport slave (
    input  in_valid, ir_in, pc_in, flush, resume, out_ready,
    output in_ready, out_valid, halted, opcode, pc, asel, bsel, loads, aluop, shift,
           write, writenum, num_rm, num_rn, num_rd, used_rmrnrd, inst_type, sximm, illegal
  );

  modport master (
    output in_valid, ir_in, pc_in, flush, resume, out_ready,
    input  in_ready, out_valid, halted, opcode, pc, asel, bsel, loads, aluop, shift,
           write, writenum, num_rm, num_rn, num_rd, used_rmrnrd, inst_type, sximm, illegal
  );
endinterface

// File: rtl/pipeline_decode_stage.sv
// Decode stage: decodes the IR at acceptance and queues the decoded payload in a
// 2-entry in-order buffer; a pushed HALT stops intake until resume.
module pipeline_decode_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int RA_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_decode_stage_if.slave bus
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [PC_W-1:0]   pc;
    logic              asel;
    logic              bsel;
    logic              loads;
    logic [1:0]        aluop;
    logic [1:0]        shift;
    logic              write;
    logic [RA_W-1:0]   writenum;
    logic [RA_W-1:0]   num_rm;
    logic [RA_W-1:0]   num_rn;
    logic [RA_W-1:0]   num_rd;
    logic [2:0]        used_rmrnrd;
    logic [5:0]        inst_type;
    logic [DATA_W-1:0] sximm;
    logic              illegal;
  } entry_t;

  function automatic entry_t decode(input logic [15:0] ir, input logic [PC_W-1:0] pc_v);
    entry_t            e;
    logic signed [7:0] imm8;
    logic signed [4:0] imm5;
    e        = '0;
    imm8     = ir[7:0];
    imm5     = ir[4:0];
    e.opcode = ir[15:13];
    e.pc     = pc_v;
    e.num_rd = RA_W'(ir[7:5]);
    case (ir[15:13])
      3'b110: begin
        case (ir[12:11])
          2'b10: begin
            e.asel        = 1'b1;
            e.bsel        = 1'b1;
            e.write       = 1'b1;
            e.writenum    = RA_W'(ir[10:8]);
            e.sximm       = DATA_W'(imm8);
          end
          2'b00: begin
            e.bsel        = 1'b1;
            e.write       = 1'b1;
            e.writenum    = RA_W'(ir[7:5]);
            e.shift       = ir[4:3];
            e.num_rm      = RA_W'(ir[2:0]);
            e.used_rmrnrd = 3'b100;
          end
          default: e.illegal = 1'b1;
        endcase
      end
      3'b101: begin
        e.aluop  = ir[12:11];
        e.shift  = ir[4:3];
        e.num_rm = RA_W'(ir[2:0]);
        case (ir[12:11])
          2'b01: begin
            e.num_rn      = RA_W'(ir[10:8]);
            e.loads       = 1'b1;
            e.used_rmrnrd = 3'b110;
          end
          2'b11: begin
            e.writenum    = RA_W'(ir[7:5]);
            e.write       = 1'b1;
            e.used_rmrnrd = 3'b100;
          end
          default: begin
            e.num_rn      = RA_W'(ir[10:8]);
            e.writenum    = RA_W'(ir[7:5]);
            e.write       = 1'b1;
            e.used_rmrnrd = 3'b110;
          end
        endcase
      end
      3'b100: begin
        e.bsel         = 1'b1;
        e.num_rm       = RA_W'(ir[10:8]);
        e.sximm        = DATA_W'(imm5);
        e.used_rmrnrd  = 3'b101;
        e.inst_type[1] = 1'b1;
      end
      3'b011: begin
        e.bsel         = 1'b1;
        e.write        = 1'b1;
        e.num_rm       = RA_W'(ir[10:8]);
        e.writenum     = RA_W'(ir[7:5]);
        e.sximm        = DATA_W'(imm5);
        e.used_rmrnrd  = 3'b100;
        e.inst_type[0] = 1'b1;
      end
      3'b111:          e.inst_type[2] = 1'b1;
      3'b001, 3'b010:  e.illegal      = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] count_q, count_d;
  entry_t     slot_q [2];
  entry_t     slot_d [2];
  entry_t     in_entry;
  entry_t     head;
  logic       in_ready_w;
  logic       out_valid_w;
  logic       push;
  logic       pop;
  logic       push_pos;

  assign in_ready_w  = (state_q == RUN) && (count_q < 2'd2);
  assign out_valid_w = (count_q != 2'd0);
  assign push        = bus.in_valid && in_ready_w && !bus.flush;
  assign pop         = out_valid_w && bus.out_ready && !bus.flush;
  assign in_entry    = decode(bus.ir_in, bus.pc_in);

  always_comb begin
    count_d  = count_q;
    state_d  = state_q;
    slot_d   = slot_q;
    push_pos = count_q[0] & ~pop;
    if (bus.flush) count_d = 2'd0;
    else           count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (pop)  slot_d[0] = slot_q[1];
    if (push) slot_d[push_pos] = in_entry;
    case (state_q)
      RUN:     if (push && in_entry.inst_type[2]) state_d = HALTED;
      HALTED:  if (bus.resume) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Stage p0 -> buffer: control is reset, stored payload is not (masked by count).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      state_q <= RUN;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign head            = out_valid_w ? slot_q[0] : '0;
  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_w;
  assign bus.halted      = (state_q == HALTED);
  assign bus.opcode      = head.opcode;
  assign bus.pc          = head.pc;
  assign bus.asel        = head.asel;
  assign bus.bsel        = head.bsel;
  assign bus.loads       = head.loads;
  assign bus.aluop       = head.aluop;
  assign bus.shift       = head.shift;
  assign bus.write       = head.write;
  assign bus.writenum    = head.writenum;
  assign bus.num_rm      = head.num_rm;
  assign bus.num_rn      = head.num_rn;
  assign bus.num_rd      = head.num_rd;
  assign bus.used_rmrnrd = head.used_rmrnrd;
  assign bus.inst_type   = head.inst_type;
  assign bus.sximm       = head.sximm;
  assign bus.illegal     = head.illegal;

endmodule

// File: tb/tb_pipeline_decode_stage.sv
// Self-checking bench for pipeline_decode_stage: directed scenarios then random traffic,
// compared against a queue-based reference model that decodes from instruction classes.
module tb_pipeline_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_decode_stage_if #(.DATA_W(16), .PC_W(8), .RA_W(3)) bus ();

  pipeline_decode_stage #(.DATA_W(16), .PC_W(8), .RA_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] ir;
    logic [7:0]  pc;
  } ent_t;

  ent_t mq[$];
  bit   m_halted;

  function automatic logic [63:0] exp_payload(input logic [15:0] ir, input logic [7:0] pc);
    logic [2:0] op, ra, rb, rc, used, writenum, num_rm, num_rn;
    logic [1:0] sub, sh, aluop, shift;
    logic [5:0] itype;
    logic [15:0] sx;
    bit   movi, movr, alu, str, ldr, hlt, ill, asel, bsel, loads, wr;
    int   v;
    op = ir[15:13]; sub = ir[12:11]; ra = ir[10:8]; rb = ir[7:5]; sh = ir[4:3]; rc = ir[2:0];
    movi = (op == 3'd6) && (sub == 2'd2);
    movr = (op == 3'd6) && (sub == 2'd0);
    alu  = (op == 3'd5);
    str  = (op == 3'd4);
    ldr  = (op == 3'd3);
    hlt  = (op == 3'd7);
    ill  = (op == 3'd1) || (op == 3'd2) || ((op == 3'd6) && sub[0]);
    asel  = movi;
    bsel  = movi || movr || str || ldr;
    loads = alu && (sub == 2'd1);
    aluop = alu ? sub : 2'd0;
    shift = (movr || alu) ? sh : 2'd0;
    wr    = movi || movr || ldr || (alu && sub != 2'd1);
    writenum = movi ? ra : (wr ? rb : 3'd0);
    num_rm   = (movr || alu) ? rc : ((str || ldr) ? ra : 3'd0);
    num_rn   = (alu && sub != 2'd3) ? ra : 3'd0;
    if (movr || ldr || (alu && sub == 2'd3)) used = 3'b100;
    else if (alu)                           used = 3'b110;
    else if (str)                           used = 3'b101;
    else                                    used = 3'b000;
    itype = {3'b000, hlt, str, ldr};
    if (movi)            v = $signed(ir[7:0]);
    else if (str || ldr) v = $signed(ir[4:0]);
    else                 v = 0;
    sx = v[15:0];
    return 64'({op, pc, asel, bsel, loads, aluop, shift, wr, writenum, num_rm, num_rn,
                rb, used, itype, sx, ill});
  endfunction

  function automatic logic [63:0] obs_payload();
    return 64'({bus.opcode, bus.pc, bus.asel, bus.bsel, bus.loads, bus.aluop, bus.shift,
                bus.write, bus.writenum, bus.num_rm, bus.num_rn, bus.num_rd, bus.used_rmrnrd,
                bus.inst_type, bus.sximm, bus.illegal});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(bus.in_ready), 64'(!m_halted && mq.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("halted", 64'(bus.halted), 64'(m_halted));
    chk("payload", obs_payload(), (mq.size() != 0) ? exp_payload(mq[0].ir, mq[0].pc) : 64'd0);
  endtask

  task automatic model_step();
    bit rdy, push, pop, was_halted;
    if (!rst_n) begin
      mq.delete();
      m_halted = 1'b0;
    end else begin
      rdy  = !m_halted && mq.size() < 2;
      push = bus.in_valid && rdy && !bus.flush;
      pop  = mq.size() != 0 && bus.out_ready && !bus.flush;
      was_halted = m_halted;
      if (bus.flush) mq.delete();
      else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back('{bus.ir_in, bus.pc_in});
      end
      if (was_halted && bus.resume)                 m_halted = 1'b0;
      else if (push && bus.ir_in[15:13] == 3'b111)  m_halted = 1'b1;
    end
  endtask

  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [15:0] ir, input logic [7:0] pc,
                       input bit ordy, input bit fl, input bit res);
    bus.in_valid  = v;
    bus.ir_in     = ir;
    bus.pc_in     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.resume    = res;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.ir_in = '0; bus.pc_in = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0; bus.resume = 1'b0;
    m_halted = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_payload", obs_payload(), 64'd0);

    // MOV immediate
    drive(1, 16'hD3FE, 8'h10, 0, 0, 0);
    chk("movi_valid", 64'(bus.out_valid), 64'd1);
    chk("movi_writenum", 64'(bus.writenum), 64'd3);
    chk("movi_sximm", 64'(bus.sximm), 64'hFFFE);
    chk("movi_asel_bsel_write", 64'({bus.asel, bus.bsel, bus.write}), 64'b111);
    chk("movi_used", 64'(bus.used_rmrnrd), 64'd0);
    chk("movi_pc", 64'(bus.pc), 64'h10);
    drive(0, 16'h0000, 8'h00, 1, 0, 0);

    // back-pressure: ADD then LDR
    drive(1, 16'hA148, 8'h20, 0, 0, 0);
    drive(1, 16'h61BF, 8'h21, 0, 0, 0);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_add_fields", 64'({bus.aluop, bus.num_rn, bus.writenum, bus.shift, bus.num_rm}),
        64'({2'b00, 3'd1, 3'd2, 2'b01, 3'd0}));
    drive(0, 16'h0000, 8'h00, 0, 0, 0);
    chk("bp_hold_pc", 64'(bus.pc), 64'h20);
    drive(0, 16'h0000, 8'h00, 1, 0, 0);
    chk("ldr_sximm", 64'(bus.sximm), 64'hFFFF);
    chk("ldr_regs", 64'({bus.num_rm, bus.writenum}), 64'({3'd1, 3'd5}));
    chk("ldr_inst_type", 64'(bus.inst_type), 64'b000001);
    drive(0, 16'h0000, 8'h00, 1, 0, 0);

    // HALT and resume
    drive(1, 16'hE000, 8'h30, 0, 0, 0);
    chk("halt_halted", 64'(bus.halted), 64'd1);
    chk("halt_in_ready", 64'(bus.in_ready), 64'd0);
    drive(0, 16'h0000, 8'h00, 1, 0, 1);
    chk("resume_halted", 64'(bus.halted), 64'd0);
    chk("resume_in_ready", 64'(bus.in_ready), 64'd1);

    // flush with count=2 and a competing push
    drive(1, 16'hA148, 8'h40, 0, 0, 0);
    drive(1, 16'hC0E5, 8'h41, 0, 0, 0);
    drive(1, 16'hD3FE, 8'h42, 1, 1, 0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    drive(0, 16'h0000, 8'h00, 1, 0, 0);

    // illegal opcodes, second one pushed during a pop at count=1
    drive(1, 16'h2000, 8'h50, 0, 0, 0);
    chk("ill_2000", 64'({bus.illegal, bus.write}), 64'b10);
    drive(1, 16'hC800, 8'h51, 1, 0, 0);
    chk("ill_c800", 64'({bus.illegal, bus.write}), 64'b10);
    chk("ill_c800_pc", 64'(bus.pc), 64'h51);
    drive(0, 16'h0000, 8'h00, 1, 0, 0);

    // reset while full and halted
    drive(1, 16'hA148, 8'h60, 0, 0, 0);
    drive(1, 16'hE000, 8'h61, 0, 0, 0);
    chk("pre_rst_halted", 64'(bus.halted), 64'd1);
    rst_n = 1'b0;
    drive(1, 16'hD3FE, 8'h62, 1, 0, 1);
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_payload", obs_payload(), 64'd0);

    // random traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) == 0);
    end
    rst_n = 1'b1;
    drive(0, 16'h0000, 8'h00, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_decode_stage.md
PIPELINE_DECODE_STAGE -- requirements
Module: pipeline_decode_stage

Interface
REQ-001 SHALL have parameters, one per line: DATA_W, default 16, datapath and sximm width (minimum 16).
REQ-002 SHALL have parameter PC_W, default 8, width of the instruction address.
REQ-003 SHALL have parameter RA_W, default 3, register-number width; RA_W=3 is the only supported value, since register fields sit at fixed IR positions.
REQ-004 SHALL have one clock and reset ports, one per line: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have input-side ports: in_valid in 1; in_ready out 1; ir_in in 16 instruction; pc_in in PC_W.
REQ-007 SHALL have control ports: flush in 1, discard all held entries; resume in 1, leave HALTED.
REQ-008 SHALL have output-side ports: out_valid out 1; out_ready in 1; halted out 1 (state==HALTED).
REQ-009 SHALL have payload outputs: opcode 3; pc PC_W; asel 1; bsel 1; loads 1; aluop 2; shift 2; write 1; writenum RA_W; num_rm RA_W; num_rn RA_W; num_rd RA_W; used_rmrnrd 3; inst_type 6; sximm DATA_W; illegal 1.

Function
REQ-010 SHALL decode combinationally at acceptance and store the decoded payload, not the raw IR, in a 2-entry in-order buffer.
REQ-011 SHALL default every decoded field to 0, except num_rd, which always equals IR[7:5].
REQ-012 SHALL decode opcode 000 as NOP: all fields 0.
REQ-013 SHALL decode opcode 110 with IR[12:11]=10 as MOV imm: asel=bsel=write=1; writenum=IR[10:8]; sximm = sign-extension of IR[7:0] to DATA_W; used=000.
REQ-014 SHALL decode opcode 110 with IR[12:11]=00 as MOV reg: bsel=write=1; writenum=IR[7:5]; shift=IR[4:3]; num_rm=IR[2:0]; used=100.
REQ-015 SHALL decode opcode 110 with IR[12:11]=01 or 11 as illegal=1 with all other fields 0.
REQ-016 SHALL decode opcode 101 as: aluop=IR[12:11]; shift=IR[4:3]; num_rm=IR[2:0].
- ADD (00) and AND (10): num_rn=IR[10:8], writenum=IR[7:5], write=1, used=110.
- CMP (01): num_rn=IR[10:8], loads=1, write=0, used=110.
- MVN (11): writenum=IR[7:5], write=1, used=100.
REQ-017 SHALL decode opcode 100 as STR: bsel=1; num_rm=IR[10:8]; sximm = sign-extension of IR[4:0]; used=101; inst_type[1]=1.
REQ-018 SHALL decode opcode 011 as LDR: bsel=1; write=1; num_rm=IR[10:8]; writenum=IR[7:5]; sximm = sign-extension of IR[4:0]; used=100; inst_type[0]=1.
REQ-019 SHALL decode opcode 111 as HALT with inst_type[2]=1; opcodes 001 and 010 SHALL decode as illegal=1; inst_type[5:3] SHALL always be 0.
REQ-020 SHALL set opcode=IR[15:13] and pc=pc_in in every entry.
REQ-021 SHALL drive in_ready = (state==RUN) && (count<2), from registered state only.
REQ-022 SHALL define push = in_valid && in_ready && !flush, and pop = out_valid && out_ready.
REQ-023 SHALL update count as count + push - pop; simultaneous push and pop at count=1 SHALL leave count=1, with the new entry at the head next cycle.
REQ-024 SHALL drive out_valid = (count!=0); the payload SHALL show the head entry, and SHALL be all-zero when count=0.
REQ-025 SHALL give a latency of 1 cycle: an entry pushed into an empty buffer is presented on the next cycle; entries SHALL leave in acceptance order.
REQ-026 SHALL hold the head payload stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on flush=1, set count=0 next cycle, drop any pop that cycle, and leave state unchanged.
REQ-028 SHALL have two states: RUN and HALTED.
- RUN->HALTED on the cycle after a HALT is pushed.
- HALTED->RUN on the cycle after resume=1.
- resume in RUN SHALL be ignored.
- The HALT entry itself SHALL still be presented and popped normally.
REQ-029 SHALL apply both flush and resume when they arrive in the same cycle.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, set count=0, state=RUN, out_valid=0, all payload outputs=0 and halted=0, overriding every other input, including mid-transfer.
REQ-031 SHALL make in_ready=1 in the first cycle after reset release.

Verification
REQ-032 SHALL cover MOV imm: push 0xD3FE at pc=0x10 -> next cycle out_valid=1, writenum=3, sximm=0xFFFE, asel=bsel=write=1, used=000, pc=0x10.
REQ-033 SHALL cover back-pressure: push 0xA148, then 0x61BF, with out_ready=0 -> count=2 and in_ready=0; head holds aluop=00, num_rn=1, writenum=2, shift=01, num_rm=0; raise out_ready -> LDR follows with sximm=0xFFFF, num_rm=1, writenum=5, inst_type=000001.
REQ-034 SHALL cover HALT: push 0xE000 -> halted=1 next cycle and in_ready=0; pulse resume -> halted=0 and in_ready=1 one cycle later.
REQ-035 SHALL cover flush: with count=2, assert flush together with in_valid=1 -> next cycle count=0 and out_valid=0; the flush-cycle instruction is never presented.
REQ-036 SHALL cover illegal opcodes: push 0x2000 and 0xC800 -> illegal=1 on each, write=0.
REQ-037 SHALL cover reset mid-operation: assert rst_n=0 with count=2 and state HALTED -> next cycle out_valid=0, halted=0, payload all-zero.
